// File: rtl/proc_run_controller.sv
// Run/step/halt sequencer for the board-level pipelined processor.
// Emits a one-cycle proc_enable advance pulse from the board clock.
module proc_run_controller #(
  parameter int RATE_DIV        = 25000000,
  parameter int CNT_W           = 25,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DB_W            = 18
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        bp_enable,
  input  logic [7:0]  bp_address,
  input  logic [7:0]  program_counter,
  input  logic        instr_stop,
  output logic        proc_enable,
  output logic [1:0]  state,
  output logic [15:0] step_count,
  output logic        halted_bp
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_HALT = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] DIV_LAST =
    CNT_W'(RATE_DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1, sync2;
  logic            stable, stable_q;
  logic [DB_W-1:0] db_cnt;
  logic            differ, db_done, press;

  state_t           st, st_n;
  logic [CNT_W-1:0] div, div_n;
  logic             pe, pe_n;
  logic [15:0]      cnt, cnt_n;
  logic             armed, armed_n;
  logic             hbp, hbp_n;
  logic             fire, div_end, bp_hit;

  assign differ  = sync2 ^ stable;
  assign db_done = differ && (db_cnt == DB_LAST);
  assign press   = stable & ~stable_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1    <= step_btn;
      sync2    <= sync1;
      stable_q <= stable;
      if (!differ) begin
        db_cnt <= '0;
      end else if (db_done) begin
        db_cnt <= '0;
        stable <= ~stable;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign div_end = (div == DIV_LAST);
  assign bp_hit  = bp_enable && armed &&
                   (program_counter == bp_address);

  always_comb begin
    st_n    = st;
    div_n   = div;
    pe_n    = 1'b0;
    cnt_n   = cnt;
    armed_n = armed;
    hbp_n   = hbp;
    fire    = 1'b0;
    unique case (st)
      S_IDLE: begin
        if (run_sw) begin
          st_n  = S_RUN;
          div_n = '0;
        end else if (press) begin
          st_n = S_STEP;
          fire = 1'b1;
        end
      end
      S_STEP: begin
        st_n = S_IDLE;
      end
      S_RUN: begin
        if (instr_stop) begin
          st_n = S_HALT;
        end else if (!run_sw) begin
          st_n  = S_IDLE;
          div_n = '0;
        end else if (div_end && bp_hit) begin
          st_n    = S_HALT;
          hbp_n   = 1'b1;
          armed_n = 1'b0;
          div_n   = '0;
        end else if (div_end) begin
          div_n = '0;
          fire  = 1'b1;
        end else begin
          div_n = div + CNT_W'(1);
        end
      end
      S_HALT: begin
        if (instr_stop) begin
          if (!run_sw) begin
            st_n  = S_IDLE;
            hbp_n = 1'b0;
          end
        end else if (press) begin
          st_n  = S_STEP;
          hbp_n = 1'b0;
          fire  = 1'b1;
        end else if (!run_sw) begin
          st_n  = S_IDLE;
          hbp_n = 1'b0;
        end
      end
      default: st_n = S_IDLE;
    endcase
    // Every advance pulse re-arms the breakpoint so it can trip again
    if (fire) begin
      pe_n    = 1'b1;
      cnt_n   = cnt + 16'd1;
      armed_n = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      st    <= S_IDLE;
      div   <= '0;
      pe    <= 1'b0;
      cnt   <= '0;
      armed <= 1'b1;
      hbp   <= 1'b0;
    end else begin
      st    <= st_n;
      div   <= div_n;
      pe    <= pe_n;
      cnt   <= cnt_n;
      armed <= armed_n;
      hbp   <= hbp_n;
    end
  end

  assign proc_enable = pe;
  assign state       = st;
  assign step_count  = cnt;
  assign halted_bp   = hbp;

endmodule

// File: tb/tb_proc_run_controller.sv
// Bench for proc_run_controller: scenario tasks plus a pulse
// scoreboard that tracks the expected step_count.
module tb_proc_run_controller;

  localparam int RATE = 4;
  localparam int DBC  = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run_sw = 1'b0;
  logic        step_btn = 1'b0;
  logic        bp_enable = 1'b0;
  logic [7:0]  bp_address = 8'h00;
  logic [7:0]  program_counter = 8'h00;
  logic        instr_stop = 1'b0;
  logic        proc_enable;
  logic [1:0]  state;
  logic [15:0] step_count;
  logic        halted_bp;

  int checks = 0;
  int errors = 0;
  logic [15:0] mcount = 16'h0;
  bit rst_seen = 1'b0;
  bit pe_q = 1'b0;

  proc_run_controller #(
    .RATE_DIV(RATE),
    .CNT_W(3),
    .DEBOUNCE_CYCLES(DBC),
    .DB_W(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .run_sw(run_sw),
    .step_btn(step_btn),
    .bp_enable(bp_enable),
    .bp_address(bp_address),
    .program_counter(program_counter),
    .instr_stop(instr_stop),
    .proc_enable(proc_enable),
    .state(state),
    .step_count(step_count),
    .halted_bp(halted_bp)
  );

  always #5 clock = ~clock;

  always @(posedge clock) rst_seen <= reset;

  // Scoreboard: count pulses, compare step_count, forbid back-to-back pulses
  always @(negedge clock) begin
    if (!rst_seen) begin
      mcount = 16'h0;
      pe_q = 1'b0;
    end else begin
      if (proc_enable === 1'b1) mcount = mcount + 16'd1;
      checks++;
      if (step_count !== mcount) begin
        errors++;
        $display("FAIL count: step_count=%0h expected %0h",
                 step_count, mcount);
      end
      checks++;
      if (pe_q && proc_enable === 1'b1) begin
        errors++;
        $display("FAIL double_pulse: proc_enable=1 expected 0");
      end
      pe_q = (proc_enable === 1'b1);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    run_sw = 1'b1;
    step_btn = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if ({proc_enable, state, step_count, halted_bp} !== 20'h0) begin
        errors++;
        $display("FAIL reset: pe=%b st=%b cnt=%0h hbp=%b expected all 0",
                 proc_enable, state, step_count, halted_bp);
      end
    end
    reset = 1'b1;
    step_btn = 1'b0;
    tick();
    checks++;
    if (state !== 2'b01) begin
      errors++;
      $display("FAIL reset_run: state=%b expected 01", state);
    end
    run_sw = 1'b0;
    tick();
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: state=%b expected 00", state);
    end
    repeat (6) tick();
  endtask

  task automatic test_free_run(input int runs);
    for (int r = 0; r < runs; r++) begin
      int len;
      logic [15:0] base;
      len = (r == 0) ? 13 : int'($urandom_range(1, 14));
      base = mcount;
      run_sw = 1'b1;
      tick();
      checks++;
      if (state !== 2'b01) begin
        errors++;
        $display("FAIL run_enter: state=%b expected 01", state);
      end
      for (int k = 1; k <= len; k++) begin
        logic exp_pe;
        logic [15:0] exp_cnt;
        tick();
        exp_pe = (k % RATE == 0);
        exp_cnt = base + 16'(k / RATE);
        checks++;
        if (proc_enable !== exp_pe || step_count !== exp_cnt) begin
          errors++;
          $display("FAIL run_pulse k=%0d: pe=%b cnt=%0h expected %b %0h",
                   k, proc_enable, step_count, exp_pe, exp_cnt);
        end
      end
      run_sw = 1'b0;
      tick();
      checks++;
      if (state !== 2'b00 || proc_enable !== 1'b0) begin
        errors++;
        $display("FAIL run_stop: state=%b pe=%b expected 00 0",
                 state, proc_enable);
      end
      repeat (3) begin
        tick();
        checks++;
        if (proc_enable !== 1'b0) begin
          errors++;
          $display("FAIL idle_quiet: pe=%b expected 0", proc_enable);
        end
      end
    end
  endtask

  task automatic test_debounce(input int rand_iters);
    int pulses;
    int steps;
    int skew;
    step_btn = 1'b1;
    repeat (2) tick();
    step_btn = 1'b0;
    pulses = 0;
    repeat (10) begin
      tick();
      if (proc_enable) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL bounce_short: pulses=%0d expected 0", pulses);
    end
    pulses = 0;
    steps = 0;
    skew = 0;
    step_btn = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 6) step_btn = 1'b0;
      tick();
      if (proc_enable) pulses++;
      if (state == 2'b10) steps++;
      if (proc_enable !== (state == 2'b10)) skew++;
    end
    checks++;
    if (pulses != 1 || steps != 1 || skew != 0) begin
      errors++;
      $display("FAIL press: pulses=%0d steps=%0d skew=%0d expected 1 1 0",
               pulses, steps, skew);
    end
    pulses = 0;
    repeat (10) begin
      tick();
      if (proc_enable) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL release: pulses=%0d expected 0", pulses);
    end
    for (int i = 0; i < rand_iters; i++) begin
      int width;
      int expn;
      width = int'($urandom_range(1, 6));
      expn = (width >= DBC) ? 1 : 0;
      pulses = 0;
      step_btn = 1'b1;
      repeat (width) begin
        tick();
        if (proc_enable) pulses++;
      end
      step_btn = 1'b0;
      repeat (12) begin
        tick();
        if (proc_enable) pulses++;
      end
      checks++;
      if (pulses != expn) begin
        errors++;
        $display("FAIL rand_press w=%0d: pulses=%0d expected %0d",
                 width, pulses, expn);
      end
    end
  endtask

  task automatic test_breakpoint();
    int pulses;
    int halts;
    bp_enable = 1'b1;
    bp_address = 8'h05;
    program_counter = 8'h03;
    run_sw = 1'b1;
    tick();
    for (int k = 1; k <= 12; k++) begin
      logic exp_pe;
      tick();
      exp_pe = (k % RATE == 0) && (k < 12);
      checks++;
      if (proc_enable !== exp_pe) begin
        errors++;
        $display("FAIL bp_pulse k=%0d: pe=%b expected %b",
                 k, proc_enable, exp_pe);
      end
      if (proc_enable) program_counter = program_counter + 8'd1;
    end
    checks++;
    if (state !== 2'b11 || halted_bp !== 1'b1) begin
      errors++;
      $display("FAIL bp_halt: state=%b hbp=%b expected 11 1",
               state, halted_bp);
    end
    repeat (4) tick();
    checks++;
    if (state !== 2'b11 || proc_enable !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: state=%b pe=%b expected 11 0",
               state, proc_enable);
    end
    pulses = 0;
    step_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 5) step_btn = 1'b0;
      if (proc_enable) begin
        pulses++;
        program_counter = program_counter + 8'd1;
      end
    end
    checks++;
    if (pulses != 1 || halted_bp !== 1'b0) begin
      errors++;
      $display("FAIL bp_step: pulses=%0d hbp=%b expected 1 0",
               pulses, halted_bp);
    end
    pulses = 0;
    halts = 0;
    repeat (20) begin
      tick();
      if (state == 2'b11) halts++;
      if (proc_enable) begin
        pulses++;
        program_counter = program_counter + 8'd1;
      end
    end
    checks++;
    if (pulses != 5 || halts != 0 || program_counter != 8'd11) begin
      errors++;
      $display("FAIL bp_resume: pulses=%0d halts=%0d pc=%0d expected 5 0 11",
               pulses, halts, program_counter);
    end
    run_sw = 1'b0;
    bp_enable = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_instr_stop(input int iters);
    for (int i = 0; i < iters; i++) begin
      int pulses;
      run_sw = 1'b1;
      tick();
      repeat (int'($urandom_range(1, 10))) tick();
      instr_stop = 1'b1;
      tick();
      checks++;
      if (state !== 2'b11 || proc_enable !== 1'b0) begin
        errors++;
        $display("FAIL stop_halt: state=%b pe=%b expected 11 0",
                 state, proc_enable);
      end
      pulses = 0;
      step_btn = 1'b1;
      repeat (5) begin
        tick();
        if (proc_enable) pulses++;
      end
      step_btn = 1'b0;
      repeat (12) begin
        tick();
        if (proc_enable) pulses++;
      end
      checks++;
      if (pulses != 0 || state !== 2'b11) begin
        errors++;
        $display("FAIL stop_press: pulses=%0d state=%b expected 0 11",
                 pulses, state);
      end
      run_sw = 1'b0;
      tick();
      checks++;
      if (state !== 2'b00) begin
        errors++;
        $display("FAIL stop_idle: state=%b expected 00", state);
      end
      instr_stop = 1'b0;
      tick();
    end
  endtask

  task automatic test_long_run();
    int pulses;
    logic [15:0] base;
    base = mcount;
    pulses = 0;
    run_sw = 1'b1;
    tick();
    repeat (4000) begin
      tick();
      if (proc_enable) pulses++;
    end
    checks++;
    if (pulses != 1000 || step_count !== base + 16'd1000) begin
      errors++;
      $display("FAIL long_run: pulses=%0d cnt=%0h expected 1000 %0h",
               pulses, step_count, base + 16'd1000);
    end
    run_sw = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_midop_reset();
    for (int d = 2; d <= 3; d++) begin
      run_sw = 1'b1;
      tick();
      repeat (d) tick();
      reset = 1'b0;
      tick();
      checks++;
      if (state !== 2'b00 || proc_enable !== 1'b0 ||
          step_count !== 16'h0) begin
        errors++;
        $display("FAIL midop_reset d=%0d: st=%b pe=%b cnt=%0h expected 00 0 0",
                 d, state, proc_enable, step_count);
      end
      run_sw = 1'b0;
      tick();
      checks++;
      if (proc_enable !== 1'b0) begin
        errors++;
        $display("FAIL midop_nopulse d=%0d: pe=%b expected 0",
                 d, proc_enable);
      end
      reset = 1'b1;
      tick();
      checks++;
      if (state !== 2'b00) begin
        errors++;
        $display("FAIL midop_after d=%0d: state=%b expected 00", d, state);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run(6);
    test_debounce(8);
    test_breakpoint();
    test_instr_stop(3);
    test_long_run();
    test_midop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
